shift_normalizer: RTL and testbench

Multi-cycle normalizer that undoes a left shift: given a 32-bit operand it finds the number of redundant leading bits and returns that count together with the left-aligned value. In logical mode the redundant bits are leading zeros; in arithmetic mode they are redundant sign bits. The block sits beside the ALU shift unit. Its count output is the shift amount the left shifter would need to normalize the operand. It uses a valid/ready handshake on both sides and scans one bit per cycle.

---
 rtl/shift_normalizer.sv | 104 ++++++++++
 tb/tb_shift_normalizer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_normalizer.sv
// Multi-cycle normalizer: counts redundant leading bits (zeros or sign copies)
// one bit per cycle and returns the left-aligned operand with the shift count.
module shift_normalizer #(
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_arith,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    out_count,
  output logic             out_zero
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             zero_q, zero_d;
  logic             redundant;
  logic             all_zero, all_one;

  assign all_zero  = (in_data == '0);
  assign all_one   = &in_data;
  assign redundant = mode_q ? (work_q[WIDTH-1] == work_q[WIDTH-2]) : ~work_q[WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      zero_q  <= zero_d;
    end
  end

  // Flush overrides accept and the output handshake alike.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    zero_d  = zero_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            mode_d  = in_arith;
            zero_d  = all_zero;
            work_d  = in_data;
            cnt_d   = '0;
            state_d = SCAN;
            if (!in_arith && all_zero) begin
              cnt_d   = CW'(WIDTH);
              state_d = DONE;
            end else if (in_arith && (all_zero || all_one)) begin
              work_d  = all_one ? {1'b1, {(WIDTH-1){1'b0}}} : '0;
              cnt_d   = CW'(WIDTH - 1);
              state_d = DONE;
            end
          end
        end
        SCAN: begin
          if (redundant) begin
            work_d = {work_q[WIDTH-2:0], 1'b0};
            cnt_d  = cnt_q + CW'(1);
          end else begin
            state_d = DONE;
          end
        end
        DONE: begin
          if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  assign out_data  = work_q;
  assign out_count = cnt_q;
  assign out_zero  = zero_q;

endmodule

// File: tb/tb_shift_normalizer.sv
// Bench for shift_normalizer: fixed vector table, corner-case sequences and
// random operands checked against an arithmetic reference model.
module tb_shift_normalizer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        in_arith = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [5:0]  out_count;
  logic        out_zero;

  int nvec = 0;
  int nerr = 0;

  shift_normalizer #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_arith(in_arith),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_count(out_count), .out_zero(out_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        a;
    logic [31:0] ed;
    int          ec;
    logic        ez;
    int          ek;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: count leading bits that equal the top bit, then derive the shift.
  function automatic void model(input logic [31:0] d, input logic a,
                                output logic [31:0] ed, output int ec,
                                output logic ez, output int ek);
    int run;
    ez = (d == 32'h0);
    run = 1;
    while (run < 32 && d[31-run] == d[31]) run++;
    if (!a) begin
      if (d == 32'h0) begin ec = 32; ek = 0; end
      else begin ec = d[31] ? 0 : run; ek = ec + 1; end
    end else begin
      if (run == 32) begin ec = 31; ek = 0; end
      else begin ec = run - 1; ek = ec + 1; end
    end
    ed = (ec >= 32) ? 32'h0 : (d << ec);
  endfunction

  task automatic do_op(input logic [31:0] d, input logic a, input int hold,
                       output logic [31:0] rd, output int rc, output logic rz,
                       output int k);
    int w;
    w = 0;
    while (!in_ready && w < 50) begin @(posedge clk); #1; w++; end
    out_ready = (hold == 0);
    in_valid  = 1'b1;
    in_data   = d;
    in_arith  = a;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = $urandom;
    in_arith = 1'($urandom_range(0, 1));
    k = 0;
    while (!out_valid && k < 40) begin @(posedge clk); #1; k++; end
    if (!out_valid) chk("timeout", 64'(out_valid), 64'd1);
    rd = out_data;
    rc = int'(out_count);
    rz = out_zero;
    for (int i = 0; i < hold; i++) begin @(posedge clk); #1; end
    if (hold > 0) chk("held_data", 64'(out_data), 64'(rd));
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_valid", 64'(out_valid), 64'd0);
  endtask

  task automatic check_op(input string tag, input logic [31:0] d, input logic a, input int hold);
    logic [31:0] ed, rd;
    int ec, ek, rc, k;
    logic ez, rz;
    model(d, a, ed, ec, ez, ek);
    do_op(d, a, hold, rd, rc, rz, k);
    chk({tag, "_data"},  64'(rd), 64'(ed));
    chk({tag, "_count"}, 64'(rc), 64'(ec));
    chk({tag, "_zero"},  64'(rz), 64'(ez));
    chk({tag, "_lat"},   64'(k),  64'(ek));
  endtask

  initial begin
    vec_t tbl[11];
    logic [31:0] rd, d;
    int rc, k;
    logic rz, a, seen;

    tbl[0]  = '{32'h00F00000, 1'b0, 32'hF0000000,  8, 1'b0,  9};
    tbl[1]  = '{32'hFFFF8000, 1'b1, 32'h80000000, 16, 1'b0, 17};
    tbl[2]  = '{32'h00000003, 1'b1, 32'h60000000, 29, 1'b0, 30};
    tbl[3]  = '{32'h00000000, 1'b0, 32'h00000000, 32, 1'b1,  0};
    tbl[4]  = '{32'hFFFFFFFF, 1'b1, 32'h80000000, 31, 1'b0,  0};
    tbl[5]  = '{32'h00000000, 1'b1, 32'h00000000, 31, 1'b1,  0};
    tbl[6]  = '{32'h00000001, 1'b0, 32'h80000000, 31, 1'b0, 32};
    tbl[7]  = '{32'h80000000, 1'b0, 32'h80000000,  0, 1'b0,  1};
    tbl[8]  = '{32'h40000000, 1'b1, 32'h40000000,  0, 1'b0,  1};
    tbl[9]  = '{32'hC0000000, 1'b1, 32'h80000000,  1, 1'b0,  2};
    tbl[10] = '{32'h00000001, 1'b1, 32'h40000000, 30, 1'b0, 31};

    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data",  64'(out_data),  64'd0);
    chk("rst_out_count", 64'(out_count), 64'd0);
    chk("rst_out_zero",  64'(out_zero),  64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      do_op(tbl[i].d, tbl[i].a, 0, rd, rc, rz, k);
      chk($sformatf("tbl%0d_data", i),  64'(rd), 64'(tbl[i].ed));
      chk($sformatf("tbl%0d_count", i), 64'(rc), 64'(tbl[i].ec));
      chk($sformatf("tbl%0d_zero", i),  64'(rz), 64'(tbl[i].ez));
      chk($sformatf("tbl%0d_lat", i),   64'(k),  64'(tbl[i].ek));
    end

    // Backpressure: result must hold while out_ready is low.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h40000000; in_arith = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 40) begin @(posedge clk); #1; k++; end
    chk("bp_lat", 64'(k), 64'd2);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_count", 64'(out_count), 64'd1);
      chk("bp_data",  64'(out_data),  64'h80000000);
      chk("bp_ready", 64'(in_ready),  64'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", 64'(out_valid), 64'd0);
    chk("bp_release_ready", 64'(in_ready),  64'd1);

    // Flush mid-scan: no result ever appears, then a fresh operand works.
    in_valid = 1'b1; in_data = 32'h00000001; in_arith = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_ready", 64'(in_ready),  64'd1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    chk("flush_no_valid", 64'(seen), 64'd0);
    check_op("post_flush", 32'h80000000, 1'b0, 0);

    // Operand offered during a flush cycle is not taken.
    flush = 1'b1; in_valid = 1'b1; in_data = 32'h00000010; in_arith = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_accept_ready", 64'(in_ready), 64'd1);

    // Asynchronous reset between edges in the middle of a scan.
    in_valid = 1'b1; in_data = 32'h00000001; in_arith = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_in_ready",  64'(in_ready),  64'd1);
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_out_data",  64'(out_data),  64'd0);
    chk("arst_out_count", 64'(out_count), 64'd0);
    chk("arst_out_zero",  64'(out_zero),  64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("arst_after_valid", 64'(out_valid), 64'd0);

    // Random operands with varied leading-bit runs and random backpressure.
    for (int i = 0; i < 200; i++) begin
      d = $urandom >> $urandom_range(0, 31);
      a = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) d = ~d;
      if ($urandom_range(0, 19) == 0) d = '0;
      if ($urandom_range(0, 19) == 0) d = '1;
      check_op($sformatf("rnd%0d", i), d, a, int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
